// File: rtl/dlbf_coeffs_stream_nch.sv
// N-channel coefficient streamer: per-channel RAMs replayed as AXI4-Stream
// packets with continuous replay, abort and lockstep fetch modes.
module dlbf_coeffs_stream_nch #(
    parameter int NUM_CH      = 4,
    parameter int TDATA_WIDTH = 64,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int RAM_DEPTH   = 1024,
    parameter int ADDR_WIDTH  = $clog2(RAM_DEPTH),
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          m_axis_clk,
    input  logic                          m_axis_rst,
    input  logic                          wr_en,
    input  logic [CH_W-1:0]               wr_ch,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [TDATA_WIDTH-1:0]        wr_data,
    input  logic                          go,
    input  logic                          abort,
    input  logic                          lockstep,
    input  logic [11:0]                   block_size,
    input  logic [11:0]                   niter,
    input  logic [ADDR_WIDTH-1:0]         rollover_addr,
    output logic [NUM_CH-1:0]             m_axis_tvalid,
    input  logic [NUM_CH-1:0]             m_axis_tready,
    output logic [NUM_CH*TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_CH*TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [NUM_CH-1:0]             m_axis_tlast,
    output logic                          busy,
    output logic [NUM_CH-1:0]             done,
    output logic                          config_err,
    output logic [NUM_CH*ADDR_WIDTH-1:0]  rd_addr
);
    localparam int DW = TDATA_WIDTH;
    localparam int AW = ADDR_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            st       [NUM_CH];
    logic [AW-1:0]     addr     [NUM_CH];
    logic [11:0]       beat_cnt [NUM_CH];
    logic [11:0]       blk_cnt  [NUM_CH];
    logic [DW-1:0]     buf0     [NUM_CH];
    logic [DW-1:0]     buf1     [NUM_CH];
    logic [1:0]        cnt      [NUM_CH];
    logic [NUM_CH-1:0] rv;
    logic [NUM_CH*DW-1:0] rq;

    logic              cfg_lock;
    logic [11:0]       cfg_bs;
    logic [11:0]       cfg_ni;
    logic [AW-1:0]     cfg_roll;

    logic [NUM_CH-1:0] run, pop, fin, space, fetch;
    logic              all_space;

    // Space counts buffered words plus the in-flight read, net of this cycle's pop
    always_comb begin
        run   = '0;
        pop   = '0;
        fin   = '0;
        space = '0;
        fetch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            run[c]   = (st[c] == RUN);
            pop[c]   = (cnt[c] != 2'd0) && m_axis_tready[c];
            fin[c]   = pop[c] && (beat_cnt[c] == cfg_bs - 12'd1) &&
                       (cfg_ni != 12'd0) && (blk_cnt[c] == cfg_ni - 12'd1);
            space[c] = run[c] &&
                       (({1'b0, cnt[c]} + {2'b0, rv[c]} - {2'b0, pop[c]}) < 3'd2);
        end
        all_space = &(space | ~run);
        for (int c = 0; c < NUM_CH; c++)
            fetch[c] = run[c] && !fin[c] && (cfg_lock ? all_space : space[c]);
    end

    assign busy         = |run;
    assign m_axis_tkeep = '1;

    always_ff @(posedge m_axis_clk) begin
        if (m_axis_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st[c]       <= IDLE;
                addr[c]     <= '0;
                beat_cnt[c] <= '0;
                blk_cnt[c]  <= '0;
                buf0[c]     <= '0;
                buf1[c]     <= '0;
                cnt[c]      <= '0;
            end
            rv         <= '0;
            done       <= '0;
            config_err <= 1'b0;
            cfg_lock   <= 1'b0;
            cfg_bs     <= '0;
            cfg_ni     <= '0;
            cfg_roll   <= '0;
        end else begin
            config_err <= 1'b0;
            if (abort) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    st[c]  <= IDLE;
                    cnt[c] <= '0;
                end
                rv <= '0;
            end else if (go && !busy) begin
                if (block_size == 12'd0) begin
                    config_err <= 1'b1;
                end else begin
                    cfg_lock <= lockstep;
                    cfg_bs   <= block_size;
                    cfg_ni   <= niter;
                    if (32'(rollover_addr) >= 32'(RAM_DEPTH))
                        cfg_roll <= AW'(RAM_DEPTH - 1);
                    else
                        cfg_roll <= rollover_addr;
                    done <= '0;
                    rv   <= '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        st[c]       <= RUN;
                        addr[c]     <= '0;
                        beat_cnt[c] <= '0;
                        blk_cnt[c]  <= '0;
                        cnt[c]      <= '0;
                    end
                end
            end else begin
                rv <= fetch;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (fetch[c])
                        addr[c] <= (addr[c] == cfg_roll) ? '0 : addr[c] + AW'(1);
                    if (fin[c]) begin
                        // Words already fetched for this channel are dropped
                        st[c]   <= IDLE;
                        done[c] <= 1'b1;
                        cnt[c]  <= '0;
                    end else begin
                        if (pop[c]) begin
                            if (beat_cnt[c] == cfg_bs - 12'd1) begin
                                beat_cnt[c] <= '0;
                                blk_cnt[c]  <= blk_cnt[c] + 12'd1;
                            end else begin
                                beat_cnt[c] <= beat_cnt[c] + 12'd1;
                            end
                        end
                        unique case ({pop[c], rv[c]})
                            2'b10: begin
                                buf0[c] <= buf1[c];
                                cnt[c]  <= cnt[c] - 2'd1;
                            end
                            2'b01: begin
                                if (cnt[c] == 2'd0)
                                    buf0[c] <= rq[c*DW +: DW];
                                else
                                    buf1[c] <= rq[c*DW +: DW];
                                cnt[c] <= cnt[c] + 2'd1;
                            end
                            2'b11: begin
                                if (cnt[c] == 2'd1) begin
                                    buf0[c] <= rq[c*DW +: DW];
                                end else begin
                                    buf0[c] <= buf1[c];
                                    buf1[c] <= rq[c*DW +: DW];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DW-1:0] mem [RAM_DEPTH];
        logic [DW-1:0] q;

        // Read-first: a same-edge write is not visible to this read
        always_ff @(posedge m_axis_clk) begin
            if (wr_en && wr_ch == CH_W'(g))
                mem[wr_addr] <= wr_data;
            if (fetch[g])
                q <= mem[addr[g]];
        end

        assign rq[g*DW +: DW]           = q;
        assign m_axis_tvalid[g]         = (cnt[g] != 2'd0);
        assign m_axis_tlast[g]          = m_axis_tvalid[g] &&
                                          (beat_cnt[g] == cfg_bs - 12'd1);
        assign m_axis_tdata[g*DW +: DW] = buf0[g];
        assign rd_addr[g*AW +: AW]      = addr[g];
    end

endmodule

// File: tb/tb_dlbf_coeffs_stream_nch.sv
// Randomized bench for dlbf_coeffs_stream_nch against a per-channel
// beat-index model: beat k carries ram[k mod (rollover+1)].
module tb_dlbf_coeffs_stream_nch;
    localparam int NC = 3;
    localparam int DW = 64;
    localparam int AW = 10;
    localparam int KW = DW / 8;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [CW-1:0]    wr_ch;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             go;
    logic             abort;
    logic             lockstep;
    logic [11:0]      block_size;
    logic [11:0]      niter;
    logic [AW-1:0]    rollover_addr;
    logic [NC-1:0]    tvalid;
    logic [NC-1:0]    tready;
    logic [NC*DW-1:0] tdata;
    logic [NC*KW-1:0] tkeep;
    logic [NC-1:0]    tlast;
    logic             busy;
    logic [NC-1:0]    done;
    logic             config_err;
    logic [NC*AW-1:0] rd_addr;

    always #5 clk = ~clk;

    dlbf_coeffs_stream_nch #(
        .NUM_CH(NC), .TDATA_WIDTH(DW), .RAM_DEPTH(1024)
    ) dut (
        .m_axis_clk(clk), .m_axis_rst(rst),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .abort(abort), .lockstep(lockstep),
        .block_size(block_size), .niter(niter), .rollover_addr(rollover_addr),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .busy(busy), .done(done), .config_err(config_err), .rd_addr(rd_addr)
    );

    logic [DW-1:0] mram [NC][64];
    int ka [NC];
    int m_bs = 1, m_ni = 0, m_roll = 0;
    int n_vec = 0, n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted beat is compared with the model RAM
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NC; c++) begin
                if (tvalid[c] && tready[c]) begin
                    if (m_ni != 0 && ka[c] >= m_bs * m_ni) begin
                        check($sformatf("extra_beat_ch%0d", c), 64'(ka[c]), 64'(m_bs * m_ni - 1));
                    end else begin
                        check($sformatf("data_ch%0d", c), tdata[c*DW +: DW],
                              mram[c][ka[c] % (m_roll + 1)]);
                        check($sformatf("tlast_ch%0d", c), 64'(tlast[c]),
                              64'((ka[c] % m_bs) == m_bs - 1));
                    end
                    ka[c]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(int bs, int ni, int roll, bit lock);
        m_bs = bs; m_ni = ni; m_roll = roll;
        for (int c = 0; c < NC; c++) ka[c] = 0;
        block_size = 12'(bs); niter = 12'(ni);
        rollover_addr = AW'(roll); lockstep = lock;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic run_idle(int budget, logic [NC-1:0] rmask);
        int n = 0;
        bit seen = 0;
        while (busy && n < budget) begin
            for (int c = 0; c < NC; c++)
                tready[c] = rmask[c] ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
            if (!seen && rmask[0] && done[1] && done[2] && !done[0]) begin
                seen = 1;
                check("busy_hold", 64'(busy), 64'd1);
            end
        end
        check("idle_timeout", 64'(busy), 64'd0);
        tready = '1;
    endtask

    task automatic check_end(int total);
        for (int c = 0; c < NC; c++)
            check($sformatf("beats_ch%0d", c), 64'(ka[c]), 64'(total));
        check("done", 64'(done), 64'({NC{1'b1}}));
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        go = 0; abort = 0; lockstep = 0; block_size = '0; niter = '0;
        rollover_addr = '0; tready = '1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata[DW-1:0] | tdata[DW +: DW] | tdata[2*DW +: DW]), 64'd0);
        check("rst_tkeep", 64'(tkeep), 64'({NC*KW{1'b1}}));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cfgerr", 64'(config_err), 64'd0);
        check("rst_rdaddr", 64'(rd_addr), 64'd0);

        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 64; i++) begin
                mram[c][i] = {$urandom, $urandom};
                wr_en = 1; wr_ch = CW'(c); wr_addr = AW'(i); wr_data = mram[c][i];
                tick();
            end
        end
        wr_en = 0;

        // Basic run with start-latency checks
        start(4, 3, 7, 0);
        check("lat_busy", 64'(busy), 64'd1);
        check("lat_tvalid0", 64'(tvalid), 64'd0);
        tick();
        check("lat_tvalid1", 64'(tvalid), 64'd0);
        tick();
        check("lat_tvalid2", 64'(tvalid), 64'({NC{1'b1}}));
        run_idle(200, '0);
        check_end(12);

        // Backpressure on ch0
        start(4, 3, 7, 0);
        run_idle(500, 3'b001);
        check_end(12);

        // Lockstep with ch1 stalled
        tready = 3'b101;
        start(4, 6, 15, 1);
        for (int n = 0; n < 20; n++) begin
            tick();
            check("skew_ch0", 64'((ka[0] - ka[1]) <= 2), 64'd1);
            check("skew_ch2", 64'((ka[2] - ka[1]) <= 2), 64'd1);
        end
        check("stalled_ch1", 64'(ka[1]), 64'd0);
        run_idle(300, '0);
        check_end(24);

        // Continuous replay, then abort and restart
        start(5, 0, int'($urandom_range(3, 20)), 0);
        for (int n = 0; n < 1000; n++) begin
            tready = NC'($urandom);
            tick();
        end
        check("cont_beats", 64'(ka[0] > 200), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_tvalid", 64'(tvalid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        tready = '1;
        start(3, 2, 7, 0);
        run_idle(200, '0);
        check_end(6);

        // Rejected go, then ignored go while busy
        block_size = '0; niter = 12'd2;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("rej_cfgerr", 64'(config_err), 64'd1);
        check("rej_busy", 64'(busy), 64'd0);
        tick();
        check("rej_pulse", 64'(config_err), 64'd0);
        start(4, 3, 7, 0);
        tick(); tick(); tick();
        block_size = 12'd2; niter = 12'd1;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("busy_go_cfgerr", 64'(config_err), 64'd0);
        run_idle(200, '0);
        check_end(12);

        // Live write ahead of the fetch pointer, plus an out-of-range channel
        tready = '0;
        start(8, 2, 15, 0);
        tick(); tick(); tick();
        mram[1][12] = {$urandom, $urandom};
        wr_en = 1; wr_ch = 2'd1; wr_addr = AW'(12); wr_data = mram[1][12];
        tick();
        wr_ch = 2'd3; wr_addr = AW'(5); wr_data = {$urandom, $urandom};
        tick();
        wr_en = 0;
        tready = '1;
        run_idle(200, '0);
        check_end(16);

        // Mid-run reset keeps RAM contents
        start(4, 3, 7, 0);
        for (int n = 0; n < 5; n++) tick();
        rst = 1'b1;
        tick();
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_tvalid", 64'(tvalid), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_rdaddr", 64'(rd_addr), 64'd0);
        rst = 1'b0;
        tick();
        start(4, 3, 7, 0);
        run_idle(200, '0);
        check_end(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dlbf_coeffs_stream_nch.md
# dlbf_coeffs_stream_nch

Parametrised N-channel coefficient streamer: per-channel RAMs loaded through a simple write port, replayed as AXI4-Stream packets toward the AI Engine PLIO inputs of the beamforming array. It generalises the four-channel coefficient master to NUM_CH channels and arbitrary width and depth. New features are continuous (infinite) replay, an abort command, and a lockstep mode that bounds inter-channel skew. Everything runs in the stream clock domain; any CSR bridging and CDC sit outside this block.

## Interface
- NUM_CH, 4, number of stream channels (1..16)
- TDATA_WIDTH, 64, stream beat width; multiple of 8
- TKEEP_WIDTH, TDATA_WIDTH/8, keep width
- RAM_DEPTH, 1024, words per channel RAM
- ADDR_WIDTH, $clog2(RAM_DEPTH), RAM address width
- CH_W, max(1,$clog2(NUM_CH)), channel select width

Ports:
- m_axis_clk  in  1  single clock for the block
- m_axis_rst  in  1  reset; synchronous and active-high
- wr_en  in  1  RAM write strobe
- wr_ch  in  CH_W  target channel; a value ≥ NUM_CH is ignored
- wr_addr  in  ADDR_WIDTH  RAM write address
- wr_data  in  TDATA_WIDTH  RAM write word
- go  in  1  start pulse
- abort  in  1  stop pulse
- lockstep  in  1  fetch mode; sampled at go
- block_size  in  12  beats per packet; sampled at go
- niter  in  12  packets per run; 0 means continuous; sampled at go
- rollover_addr  in  ADDR_WIDTH  last RAM address read before wrapping to 0; sampled at go
- m_axis_tvalid  out  NUM_CH  per-channel valid
- m_axis_tready  in  NUM_CH  per-channel ready
- m_axis_tdata  out  NUM_CH*TDATA_WIDTH  channel c occupies bits [c*TDATA_WIDTH +: TDATA_WIDTH]
- m_axis_tkeep  out  NUM_CH*TKEEP_WIDTH  all ones, constant
- m_axis_tlast  out  NUM_CH  last beat of packet
- busy  out  1  OR of all channels in RUN
- done  out  NUM_CH  sticky; set when a channel completes its run
- config_err  out  1  one-cycle pulse when a go is rejected
- rd_addr  out  NUM_CH*ADDR_WIDTH  next fetch address per channel

## Operation
- **Per-channel FSM: IDLE → RUN → IDLE.**
  - go while busy=0 and block_size≠0: all channels enter RUN and configuration is latched.
  - At go: address, beat count, block count and the 2-entry output buffer are cleared; done is cleared.
  - go while busy=1 is ignored.
  - go with block_size=0 is rejected: config_err pulses and state is unchanged.
- **Fetch.**
  - RAM is read-first with 1-cycle read latency.
  - A fetch is issued when the buffer has free space, counting in-flight reads.
  - Address increments per fetch; after fetching rollover_addr it wraps to 0.
  - A latched rollover_addr ≥ RAM_DEPTH is clamped to RAM_DEPTH-1.
  - Address wrap is independent of packet boundaries.
- **Output.**
  - The buffer head drives tdata and tvalid.
  - tlast=1 when beat_cnt = block_size-1.
  - On each accepted beat (tvalid & tready): beat_cnt increments. At tlast, beat_cnt resets to 0 and blk_cnt increments.
- **Completion.**
  - When niter≠0 and the tlast beat with blk_cnt = niter-1 is accepted: that channel sets done, returns to IDLE, and issues no further fetches.
  - Any fetched-but-unsent words are discarded.
  - When niter=0, the channel runs until abort.
- **Modes.**
  - lockstep=0: each channel fetches independently.
  - lockstep=1: fetches are issued to all channels together, only when every RUN channel has space. Skew between any two channels is therefore ≤ 2 beats.
- **abort (priority over go in the same cycle).**
  - All channels go to IDLE on the next edge and tvalid drops.
  - This AXIS violation is accepted for abort only.
  - done is not set by abort.
- **Writes.**
  - Permitted in any state.
  - A same-cycle read of the same address returns the old data.

## Timing
- **Reset values:** tvalid 0, tlast 0, tdata 0, tkeep all ones, busy 0, done 0, config_err 0, rd_addr 0. All FSMs are in IDLE and buffers are empty.
- **Start latency:** go sampled at edge 0 → busy=1 after edge 0, first tvalid after edge 2.
- **Throughput:** with tready held high, 1 beat/cycle sustained per channel, including across address wrap and packet boundaries.
- **AXIS rules:**
  - tvalid never depends combinationally on tready.
  - Once asserted, tvalid and tdata stay stable until accepted; abort and reset are the only exceptions.
- **done:** rises the cycle after the final beat is accepted; busy falls in the same cycle once all channels are IDLE.
- **Counters:** 12-bit beat and block counters; niter=4095 gives 4095 packets. Address arithmetic is ADDR_WIDTH modulo, after the rollover compare.
- **Mid-run reset:** behaves like power-on reset within 1 cycle; RAM contents are retained.

## Test plan
- **Basic run:** load ch c word i = {c,i}; block_size=4, niter=3, rollover=7, tready=1. Each channel emits 12 beats with data i=0..7,0..3, tlast on beats 3, 7 and 11, and done asserts.
- **Backpressure:** independent mode, ch0 tready toggling, other channels high. Ch0 data order is identical to the basic run with no loss or duplication. Other channels finish earlier, and busy stays high until ch0 is done.
- **Lockstep skew:** lockstep=1, ch1 tready held low for 20 cycles, others high. Other channels stall after at most 2 beats beyond ch1; after release all complete with correct data.
- **Continuous + abort:** niter=0, block_size=5, run 1000 cycles, then abort. The beat sequence wraps correctly at rollover. tvalid is 0 the cycle after abort, done stays 0, and a following go restarts at address 0.
- **Rejections:** go with block_size=0 → config_err pulse and busy=0. go while busy → ignored; the current run is unaffected.
- **Live write:** during a run, write a new value at an address ahead of the fetch pointer. The new value appears in the stream; a write to wr_ch=NUM_CH changes nothing.
